dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Sequences and shares the single-port data memory between two requesters: the pipeline MEM stage (CPU port) and a debug/loader port (DBG port). A small FSM latches one request at a time, holds the memory address, write data and write enable stable for a configurable number of wait states, and issues exactly one write strobe per write. It then returns registered read data with a one-cycle acknowledge. The block sits between the MEM-stage/hazard unit and data_memory.

Parameters:
N, 32, address width
M, 32, data width
WAIT_STATES, 0, extra memory cycles per access (0..15)
STARVE_LIMIT, 4, consecutive CPU grants allowed while DBG is pending (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
cpu_req  in  1  CPU access request, held until cpu_ack
cpu_we  in  1  CPU write (1) / read (0)
cpu_adr  in  N  CPU address
cpu_wdata  in  M  CPU write data
cpu_rdata  out  M  CPU read data, valid while cpu_ack=1
cpu_ack  out  1  one-cycle completion pulse
cpu_stall  out  1  cpu_req & ~cpu_ack, combinational, to hazard unit
dbg_req  in  1  DBG request, held until dbg_ack
dbg_we  in  1  DBG write/read
dbg_adr  in  N  DBG address
dbg_wdata  in  M  DBG write data
dbg_rdata  out  M  DBG read data, valid while dbg_ack=1
dbg_ack  out  1  one-cycle completion pulse
mem_we  out  1  to data_memory write_enable
mem_adr  out  N  to data_memory adr
mem_din  out  M  to data_memory din
mem_dout  in  M  from data_memory dout (combinational read)

Behaviour:
- One clock (clk); reset is synchronous and active-high. Reset state: IDLE. Reset values: acks 0, rdata 0, latched regs 0, counters 0, mem_we 0.
- States are IDLE, BUSY and RESP.
- IDLE:
  - If any request is present, select an owner and latch we/adr/wdata.
  - Load wait_cnt with WAIT_STATES and move to BUSY.
  - With no request, stay in IDLE.
- Arbitration:
  - CPU has priority.
  - Exception: DBG wins if dbg_req=1 and starve_cnt==STARVE_LIMIT.
  - starve_cnt increments on each CPU grant while dbg_req=1, saturating at STARVE_LIMIT.
  - starve_cnt clears on a DBG grant or when dbg_req=0.
- BUSY:
  - mem_adr and mem_din are driven from the latched regs.
  - If wait_cnt!=0: decrement it and stay in BUSY.
  - If wait_cnt==0 (final cycle):
    - mem_we = latched we. This is the only cycle mem_we can be 1.
    - Capture mem_dout into the owner's rdata reg. Capture on writes too; the value is don't-care for the requester.
    - Move to RESP.
- RESP:
  - The owner's ack is 1 for exactly this cycle. The next state is IDLE unconditionally, so no grant is made in RESP.
  - rdata holds its value until the next completion for that port.
- Outside BUSY: mem_we=0, mem_adr=0, mem_din=0.
- Latency: a request sampled in IDLE at cycle t gives ack in cycle t+WAIT_STATES+2. Back-to-back accesses are separated by one IDLE cycle.
- A requester whose req is still high in the cycle after ack is treated as a new access.
- Requests are not sampled during BUSY or RESP. Changes to the non-owner's inputs have no effect.
- Simultaneous requests in IDLE: CPU is granted unless starvation forces DBG. The loser stays pending.
- Reset mid-BUSY: the access is dropped. If the final cycle has not yet occurred, no write is issued and no ack is given.
- Address and data pass through unchanged. Range checking belongs to data_memory.

Optional Feature:
- Macro: DMEM_ARB_DBG_EN.
- Defined: full two-port arbitration as above.
- Undefined:
  - DBG ports still exist, but dbg_req is ignored.
  - dbg_ack and dbg_rdata are tied to 0.
  - starve_cnt logic is removed.
  - Only the CPU is ever granted; CPU timing is unchanged.

Decomposition:
- Package dmem_arb_pkg holds:
  - typedef enum state_t {IDLE, BUSY, RESP};
  - typedef enum owner_t {OWN_CPU, OWN_DBG};
  - localparam WAIT_W=4 for the wait counter width.
- One natural sub-module, dmem_arb_prio: combinational grant selection plus the registered starve_cnt. Inputs: cpu_req, dbg_req, grant_strobe. Output: owner.

Test Plan:
1. WAIT_STATES=0, memory preloaded mem[0x08]=10. CPU read adr=0x08 at cycle 0 -> cpu_stall=1 in cycles 0–1; cpu_ack=1 and cpu_rdata=10 in cycle 2; mem_we=0 throughout.
2. CPU write adr=0x04, wdata=0xDEAD_BEEF -> mem_we=1 in exactly one cycle (cycle 1), with mem_adr=0x04. A following CPU read of 0x04 returns 0xDEAD_BEEF.
3. cpu_req and dbg_req both asserted in cycle 0 -> CPU acked at cycle 2, DBG granted at cycle 3 and acked at cycle 5.
4. STARVE_LIMIT=2, CPU requests back-to-back, dbg_req held high -> grant order CPU, CPU, DBG, CPU. starve_cnt returns to 0 after the DBG grant.
5. WAIT_STATES=3, CPU write; reset asserted in BUSY cycle 2 -> mem_we never 1, no cpu_ack, outputs at reset values the next cycle. A new read afterwards shows the old memory value.
6. DMEM_ARB_DBG_EN undefined, dbg_req=1 held for 20 cycles -> dbg_ack stays 0; CPU reads still complete with 2-cycle latency.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
// Define DMEM_ARB_DBG_EN to enable the debug/loader port; otherwise only the CPU is served.
package dmem_arb_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic {OWN_CPU, OWN_DBG} owner_t;

    localparam int WAIT_W = 4;

`ifdef DMEM_ARB_DBG_EN
    localparam bit DBG_EN = 1'b1;
`else
    localparam bit DBG_EN = 1'b0;
`endif

endpackage

// File: rtl/dmem_arb_prio.sv
// Grant selection between CPU and DBG with a starvation counter for DBG.
// With DMEM_ARB_DBG_EN undefined the counter is absent and the CPU always owns the grant.
module dmem_arb_prio
    import dmem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   cpu_req,
    input  logic   dbg_req,
    input  logic   grant_strobe,
    output owner_t owner
);

`ifdef DMEM_ARB_DBG_EN
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             starved;

    assign starved = (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    always_comb begin
        // NOTE: every output gets a default first, so no path through the block infers a latch.
        owner        = OWN_CPU;
        starve_cnt_d = starve_cnt_q;
        if (dbg_req && (!cpu_req || starved)) begin
            owner = OWN_DBG;
        end
        // The count only measures CPU wins while DBG is actually waiting.
        if (!dbg_req) begin
            starve_cnt_d = '0;
        end else if (grant_strobe) begin
            if (owner == OWN_DBG) begin
                starve_cnt_d = '0;
            end else if (!starved) begin
                starve_cnt_d = starve_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`else
    logic unused_ok;

    assign owner     = OWN_CPU;
    assign unused_ok = ^{clk, reset, cpu_req, dbg_req, grant_strobe};
`endif

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage (CPU) and a debug/loader port (DBG).
// The DBG port is live only when DMEM_ARB_DBG_EN is defined.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int N            = 32,
    parameter int M            = 32,
    parameter int WAIT_STATES  = 0,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cpu_req,
    input  logic         cpu_we,
    input  logic [N-1:0] cpu_adr,
    input  logic [M-1:0] cpu_wdata,
    output logic [M-1:0] cpu_rdata,
    output logic         cpu_ack,
    output logic         cpu_stall,
    input  logic         dbg_req,
    input  logic         dbg_we,
    input  logic [N-1:0] dbg_adr,
    input  logic [M-1:0] dbg_wdata,
    output logic [M-1:0] dbg_rdata,
    output logic         dbg_ack,
    output logic         mem_we,
    output logic [N-1:0] mem_adr,
    output logic [M-1:0] mem_din,
    input  logic [M-1:0] mem_dout
);

    state_t            state_q, state_d;
    owner_t            owner_q, owner_d;
    owner_t            grant_owner;
    logic              we_q, we_d;
    logic [N-1:0]      adr_q, adr_d;
    logic [M-1:0]      wdata_q, wdata_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [M-1:0]      cpu_rdata_q, cpu_rdata_d;
    logic [M-1:0]      dbg_rdata_q, dbg_rdata_d;
    logic              cpu_ack_q, cpu_ack_d;
    logic              dbg_ack_q, dbg_ack_d;
    logic              dbg_req_eff;
    logic              grant_strobe;
    logic              busy;
    logic              final_cycle;

    assign dbg_req_eff  = dbg_req & DBG_EN;
    assign grant_strobe = (state_q == IDLE) && (cpu_req || dbg_req_eff);
    assign busy         = (state_q == BUSY);
    assign final_cycle  = busy && (wait_cnt_q == '0);

    dmem_arb_prio #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_prio (
        .clk          (clk),
        .reset        (reset),
        .cpu_req      (cpu_req),
        .dbg_req      (dbg_req_eff),
        .grant_strobe (grant_strobe),
        .owner        (grant_owner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        we_d        = we_q;
        adr_d       = adr_q;
        wdata_d     = wdata_q;
        wait_cnt_d  = wait_cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        cpu_ack_d   = 1'b0;
        dbg_ack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_strobe) begin
                    owner_d    = grant_owner;
                    wait_cnt_d = WAIT_W'(WAIT_STATES);
                    state_d    = BUSY;
                    if (grant_owner == OWN_DBG) begin
                        we_d    = dbg_we;
                        adr_d   = dbg_adr;
                        wdata_d = dbg_wdata;
                    end else begin
                        we_d    = cpu_we;
                        adr_d   = cpu_adr;
                        wdata_d = cpu_wdata;
                    end
                end
            end
            BUSY: begin
                if (wait_cnt_q != '0) begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end else begin
                    // Final cycle: capture read data (also on writes) and raise ack for RESP.
                    state_d = RESP;
                    if (owner_q == OWN_DBG) begin
                        dbg_rdata_d = mem_dout;
                        dbg_ack_d   = 1'b1;
                    end else begin
                        cpu_rdata_d = mem_dout;
                        cpu_ack_d   = 1'b1;
                    end
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            owner_q     <= OWN_CPU;
            we_q        <= 1'b0;
            adr_q       <= '0;
            wdata_q     <= '0;
            wait_cnt_q  <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_ack_q   <= 1'b0;
            dbg_ack_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            adr_q       <= adr_d;
            wdata_q     <= wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            cpu_ack_q   <= cpu_ack_d;
            dbg_ack_q   <= dbg_ack_d;
        end
    end

    // Memory side is quiet outside BUSY; the write strobe exists only in the final cycle.
    assign mem_we  = final_cycle & we_q;
    assign mem_adr = busy ? adr_q : '0;
    assign mem_din = busy ? wdata_q : '0;

    assign cpu_rdata = cpu_rdata_q;
    assign cpu_ack   = cpu_ack_q;
    assign cpu_stall = cpu_req & ~cpu_ack_q;
    assign dbg_rdata = dbg_rdata_q & {M{DBG_EN}};
    assign dbg_ack   = dbg_ack_q & DBG_EN;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: one instance with WAIT_STATES=0/STARVE_LIMIT=2, one with WAIT_STATES=3.
// DBG-port scenarios follow DMEM_ARB_DBG_EN; the disabled build checks that DBG is ignored.
module tb_dmem_arbiter;

    logic clk;
    logic reset;
    logic reset_w;
    logic init_mem;

    logic        cpu_req, cpu_we, cpu_ack, cpu_stall;
    logic [31:0] cpu_adr, cpu_wdata, cpu_rdata;
    logic        dbg_req, dbg_we, dbg_ack;
    logic [31:0] dbg_adr, dbg_wdata, dbg_rdata;
    logic        mem_we;
    logic [31:0] mem_adr, mem_din, mem_dout;

    logic        cpu_req_w, cpu_we_w, cpu_ack_w, cpu_stall_w;
    logic [31:0] cpu_adr_w, cpu_wdata_w, cpu_rdata_w;
    logic        dbg_ack_w;
    logic [31:0] dbg_rdata_w;
    logic        mem_we_w;
    logic [31:0] mem_adr_w, mem_din_w, mem_dout_w;

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_w [0:255];

    int checks = 0;
    int errors = 0;
    int dbg_ack_cnt = 0;
    int we_w_cnt = 0;

    dmem_arbiter #(.N(32), .M(32), .WAIT_STATES(0), .STARVE_LIMIT(2)) dut (
        .clk (clk), .reset (reset),
        .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_adr (cpu_adr), .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata), .cpu_ack (cpu_ack), .cpu_stall (cpu_stall),
        .dbg_req (dbg_req), .dbg_we (dbg_we), .dbg_adr (dbg_adr), .dbg_wdata (dbg_wdata),
        .dbg_rdata (dbg_rdata), .dbg_ack (dbg_ack),
        .mem_we (mem_we), .mem_adr (mem_adr), .mem_din (mem_din), .mem_dout (mem_dout)
    );

    dmem_arbiter #(.N(32), .M(32), .WAIT_STATES(3), .STARVE_LIMIT(4)) dut_w (
        .clk (clk), .reset (reset_w),
        .cpu_req (cpu_req_w), .cpu_we (cpu_we_w), .cpu_adr (cpu_adr_w), .cpu_wdata (cpu_wdata_w),
        .cpu_rdata (cpu_rdata_w), .cpu_ack (cpu_ack_w), .cpu_stall (cpu_stall_w),
        .dbg_req (1'b0), .dbg_we (1'b0), .dbg_adr (32'h0), .dbg_wdata (32'h0),
        .dbg_rdata (dbg_rdata_w), .dbg_ack (dbg_ack_w),
        .mem_we (mem_we_w), .mem_adr (mem_adr_w), .mem_din (mem_din_w), .mem_dout (mem_dout_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational-read memories standing in for data_memory.
    assign mem_dout   = mem_a[mem_adr[7:0]];
    assign mem_dout_w = mem_w[mem_adr_w[7:0]];

    always @(posedge clk) begin
        // NOTE: the arrays are never reset; only the words the tests read are seeded.
        if (init_mem) begin
            mem_a[8'h08] <= 32'd10;
            mem_a[8'h10] <= 32'h0000_0055;
            mem_w[8'h04] <= 32'h0000_1234;
        end else begin
            if (mem_we)   mem_a[mem_adr[7:0]]   <= mem_din;
            if (mem_we_w) mem_w[mem_adr_w[7:0]] <= mem_din_w;
        end
    end

    always @(negedge clk) begin
        if (dbg_ack)  dbg_ack_cnt++;
        if (mem_we_w) we_w_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One CPU access on the WAIT_STATES=0 instance; leaves the bench in the IDLE cycle after ack.
    task automatic cpu_access(input string tag, input logic we, input logic [31:0] adr,
                              input logic [31:0] wdata, input int exp_lat, input logic [31:0] exp_rdata);
        int lat = 0;
        int we_cnt = 0;
        int we_at = -1;
        bit done = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_adr   = adr;
        cpu_wdata = wdata;
        while (!done && lat <= 30) begin
            @(negedge clk);
            if (mem_we) begin
                we_cnt++;
                we_at = lat;
                check({tag, "_wadr"}, mem_adr, adr);
                check({tag, "_wdin"}, mem_din, wdata);
            end
            if (cpu_ack) begin
                done = 1'b1;
            end else begin
                check({tag, "_stall"}, {31'b0, cpu_stall}, 32'd1);
                next_cycle();
                lat++;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_we_cnt"}, we_cnt, {31'b0, we});
        check({tag, "_stall_at_ack"}, {31'b0, cpu_stall}, 32'd0);
        if (we) check({tag, "_we_at"}, we_at, exp_lat - 1);
        else    check({tag, "_rdata"}, cpu_rdata, exp_rdata);
        next_cycle();
        cpu_req = 1'b0;
    endtask

    initial begin
        int lat;
`ifdef DMEM_ARB_DBG_EN
        int cpu_ack_at, dbg_ack_at, dbg_busy_at;
        bit cpu_done, dbg_done, dbg_seen;
        int order[$];
        int exp_order[4] = '{0, 0, 1, 0};
`endif
        reset = 1'b1; reset_w = 1'b1; init_mem = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_adr = '0; cpu_wdata = '0;
        dbg_req = 1'b0; dbg_we = 1'b0; dbg_adr = '0; dbg_wdata = '0;
        cpu_req_w = 1'b0; cpu_we_w = 1'b0; cpu_adr_w = '0; cpu_wdata_w = '0;
        repeat (3) next_cycle();
        reset = 1'b0; reset_w = 1'b0; init_mem = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_cpu_ack",   {31'b0, cpu_ack},   32'd0);
        check("rst_cpu_rdata", cpu_rdata,          32'd0);
        check("rst_dbg_ack",   {31'b0, dbg_ack},   32'd0);
        check("rst_dbg_rdata", dbg_rdata,          32'd0);
        check("rst_mem_we",    {31'b0, mem_we},    32'd0);
        check("rst_mem_adr",   mem_adr,            32'd0);
        check("rst_mem_din",   mem_din,            32'd0);
        check("rst_stall",     {31'b0, cpu_stall}, 32'd0);
        next_cycle();

        // Test 1: CPU read, ack two cycles after the request
        cpu_access("t1_rd", 1'b0, 32'h08, 32'h0, 2, 32'd10);

        // Test 2: CPU write with one strobe, then read back
        cpu_access("t2_wr", 1'b1, 32'h04, 32'hDEAD_BEEF, 2, 32'h0);
        cpu_access("t2_rd", 1'b0, 32'h04, 32'h0, 2, 32'hDEAD_BEEF);

`ifdef DMEM_ARB_DBG_EN
        // Test 3: simultaneous requests, CPU first, DBG follows after one IDLE cycle
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h08;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 32'h10;
        cpu_ack_at = -1; dbg_ack_at = -1; dbg_busy_at = -1;
        cpu_done = 1'b0; dbg_done = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (cpu_ack && cpu_ack_at < 0) cpu_ack_at = c;
            if (mem_adr == 32'h10 && dbg_busy_at < 0) dbg_busy_at = c;
            if (dbg_ack && dbg_ack_at < 0) begin
                dbg_ack_at = c;
                check("t3_dbg_rdata", dbg_rdata, 32'h55);
            end
            next_cycle();
            if (cpu_ack_at >= 0) cpu_req = 1'b0;
            if (dbg_ack_at >= 0) dbg_req = 1'b0;
        end
        check("t3_cpu_ack_at",  cpu_ack_at,  32'd2);
        check("t3_dbg_busy_at", dbg_busy_at, 32'd4);
        check("t3_dbg_ack_at",  dbg_ack_at,  32'd5);

        // Test 4: STARVE_LIMIT=2 forces DBG in as the third grant
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_adr = 32'h08;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_adr = 32'h10;
        for (int c = 0; c < 30 && order.size() < 4; c++) begin
            @(negedge clk);
            dbg_seen = dbg_ack;
            if (cpu_ack) order.push_back(0);
            if (dbg_ack) begin
                order.push_back(1);
                check("t4_starve_clr", 32'(dut.u_prio.starve_cnt_q), 32'd0);
                check("t4_dbg_rdata", dbg_rdata, 32'h55);
            end
            next_cycle();
            if (dbg_seen) dbg_req = 1'b0;
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        check("t4_grants", order.size(), 32'd4);
        for (int i = 0; i < order.size() && i < 4; i++) begin
            check($sformatf("t4_order%0d", i), order[i], exp_order[i]);
        end
        next_cycle();
        check("t4_starve_idle", 32'(dut.u_prio.starve_cnt_q), 32'd0);
        check("dbg_ack_total", dbg_ack_cnt, 32'd2);
`else
        // Test 6: DBG ignored; CPU timing unchanged
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_adr = 32'h10; dbg_wdata = 32'hBAD0_BAD0;
        next_cycle();
        @(negedge clk);
        check("t6_mem_adr_idle", mem_adr, 32'd0);
        check("t6_mem_we_idle",  {31'b0, mem_we}, 32'd0);
        next_cycle();
        cpu_access("t6_rd1", 1'b0, 32'h08, 32'h0, 2, 32'd10);
        cpu_access("t6_rd2", 1'b0, 32'h10, 32'h0, 2, 32'h55);
        repeat (10) next_cycle();
        dbg_req = 1'b0;
        check("t6_dbg_ack_cnt", dbg_ack_cnt, 32'd0);
        check("t6_dbg_rdata",   dbg_rdata,   32'd0);
`endif

        // Test 5: reset in the second BUSY cycle of a write drops it completely
        cpu_req_w = 1'b1; cpu_we_w = 1'b1; cpu_adr_w = 32'h04; cpu_wdata_w = 32'hFFFF_0000;
        for (int c = 0; c < 3; c++) begin
            if (c == 2) reset_w = 1'b1;
            @(negedge clk);
            check($sformatf("t5_ack_c%0d", c), {31'b0, cpu_ack_w}, 32'd0);
            if (c == 1) check("t5_stall_busy", {31'b0, cpu_stall_w}, 32'd1);
            next_cycle();
        end
        reset_w = 1'b0;
        cpu_req_w = 1'b0;
        @(negedge clk);
        check("t5_post_ack",   {31'b0, cpu_ack_w},   32'd0);
        check("t5_post_rdata", cpu_rdata_w,          32'd0);
        check("t5_post_we",    {31'b0, mem_we_w},    32'd0);
        check("t5_post_adr",   mem_adr_w,            32'd0);
        check("t5_post_din",   mem_din_w,            32'd0);
        check("t5_post_stall", {31'b0, cpu_stall_w}, 32'd0);
        repeat (4) next_cycle();
        cpu_req_w = 1'b1; cpu_we_w = 1'b0; cpu_adr_w = 32'h04;
        lat = 0;
        while (lat <= 30) begin
            @(negedge clk);
            if (cpu_ack_w) break;
            next_cycle();
            lat++;
        end
        check("t5_rd_lat",   lat,         32'd5);
        check("t5_rd_rdata", cpu_rdata_w, 32'h1234);
        next_cycle();
        cpu_req_w = 1'b0;
        repeat (2) next_cycle();
        check("t5_we_never", we_w_cnt,                32'd0);
        check("t5_dbg_ack",  {31'b0, dbg_ack_w},      32'd0);
        check("t5_dbg_rd",   dbg_rdata_w,             32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
